// File: rtl/vram_blit_engine_if.sv
// Bus bundle for the blit engine: command handshake, CPU bus path and VRAM port A.
// The engine uses the slave view; the surrounding system (or a bench) uses the master view.
interface vram_blit_engine_if #(
    parameter int AW = 20,
    parameter int DW = 12,
    parameter int CW = 10
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [CW-1:0] cmd_dx;
    logic [CW-1:0] cmd_dy;
    logic [CW-1:0] cmd_sx;
    logic [CW-1:0] cmd_sy;
    logic [CW-1:0] cmd_w;
    logic [CW-1:0] cmd_h;
    logic [DW-1:0] cmd_color;
    logic          abort;
    logic          busy;
    logic          done;

    logic          cpu_en;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;

    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_din;
    logic [DW-1:0] vram_dout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_sx, cmd_sy, cmd_w, cmd_h, cmd_color, abort,
        output cmd_ready, busy, done,
        input  cpu_en, cpu_we, cpu_addr, cpu_din,
        output cpu_dout,
        output vram_addr, vram_we, vram_din,
        input  vram_dout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_sx, cmd_sy, cmd_w, cmd_h, cmd_color, abort,
        input  cmd_ready, busy, done,
        output cpu_en, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout,
        input  vram_addr, vram_we, vram_din,
        output vram_dout
    );
endinterface

// File: rtl/vram_blit_engine.sv
// VRAM port-A fill/copy engine. The CPU bus path always owns the port when it asks;
// the engine only advances in cycles the CPU leaves free.
module vram_blit_engine #(
    parameter int AW = 20,
    parameter int DW = 12,
    parameter int CW = 10
) (
    input  logic              clk,
    input  logic              rst,
    vram_blit_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_CRD  = 3'd2;
    localparam logic [2:0] S_CCAP = 3'd3;
    localparam logic [2:0] S_CWR  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          op_q, op_d;
    logic [CW-1:0] dx_q, dx_d;
    logic [CW-1:0] dy_q, dy_d;
    logic [CW-1:0] sx_q, sx_d;
    logic [CW-1:0] sy_q, sy_d;
    logic [CW-1:0] w_q, w_d;
    logic [CW-1:0] h_q, h_d;
    logic [DW-1:0] color_q, color_d;
    logic [DW-1:0] pix_q, pix_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          xdesc_q, xdesc_d;
    logic          ydesc_q, ydesc_d;

    logic          grant;
    logic          adv;
    logic          busy;
    logic          last_col;
    logic          last_row;
    logic [CW-1:0] xoff, yoff;
    logic [CW-1:0] dst_x, dst_y, src_x, src_y;
    logic [AW-1:0] dst_addr, src_addr;
    logic [AW-1:0] eng_addr;
    logic          eng_we;
    logic [DW-1:0] eng_din;

    assign grant = !bus.cpu_en;
    assign busy  = (state_q == S_FILL) || (state_q == S_CRD) ||
                   (state_q == S_CCAP) || (state_q == S_CWR);

    // Counters always run upward; a descending scan is obtained by mirroring the offset.
    assign xoff = xdesc_q ? (w_q - CW'(1) - col_q) : col_q;
    assign yoff = ydesc_q ? (h_q - CW'(1) - row_q) : row_q;

    assign dst_x    = dx_q + xoff;
    assign dst_y    = dy_q + yoff;
    assign src_x    = sx_q + xoff;
    assign src_y    = sy_q + yoff;
    assign dst_addr = {dst_y, dst_x};
    assign src_addr = {src_y, src_x};

    assign last_col = (col_q == w_q - CW'(1));
    assign last_row = (row_q == h_q - CW'(1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        pix_d   = pix_q;
        col_d   = col_q;
        row_d   = row_q;
        xdesc_d = xdesc_q;
        ydesc_d = ydesc_q;
        adv     = 1'b0;
        eng_we  = 1'b0;
        eng_addr = dst_addr;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    dx_d    = bus.cmd_dx;
                    dy_d    = bus.cmd_dy;
                    sx_d    = bus.cmd_sx;
                    sy_d    = bus.cmd_sy;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                    col_d   = '0;
                    row_d   = '0;
                    // Scan away from the overlap so a scroll never reads an already-written pixel.
                    xdesc_d = bus.cmd_op && (bus.cmd_sx < bus.cmd_dx);
                    ydesc_d = bus.cmd_op && (bus.cmd_sy < bus.cmd_dy);
                    if ((bus.cmd_w == '0) || (bus.cmd_h == '0)) begin
                        state_d = S_FIN;
                    end else if (bus.cmd_op) begin
                        state_d = S_CRD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (grant) begin
                    eng_we = 1'b1;
                    adv    = 1'b1;
                end
            end
            S_CRD: begin
                eng_addr = src_addr;
                if (grant) begin
                    state_d = S_CCAP;
                end
            end
            S_CCAP: begin
                // Read data belongs to the address of the previous cycle, whoever owns the port now.
                pix_d   = bus.vram_dout;
                state_d = S_CWR;
            end
            S_CWR: begin
                if (grant) begin
                    eng_we  = 1'b1;
                    adv     = 1'b1;
                    state_d = S_CRD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    state_d = S_FIN;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (bus.abort && busy) begin
            state_d = S_IDLE;
        end
    end

    assign eng_din = op_q ? pix_q : color_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            pix_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            xdesc_q <= 1'b0;
            ydesc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xdesc_q <= xdesc_d;
            ydesc_q <= ydesc_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = busy;
    assign bus.done      = (state_q == S_FIN);

    assign bus.vram_addr = bus.cpu_en ? bus.cpu_addr : eng_addr;
    assign bus.vram_we   = bus.cpu_en ? bus.cpu_we   : eng_we;
    assign bus.vram_din  = bus.cpu_en ? bus.cpu_din  : eng_din;
    assign bus.cpu_dout  = bus.vram_dout;
endmodule
